xvk_cam_alloc: RTL and testbench
================================

Name: xvk_cam_alloc

Overview:
- Slot allocator and access sequencer that sits directly upstream of xvk_cam and owns its write, search and ignore ports.
- Manages a valid bitmap of CAM slots and accepts insert, lookup, release and flush requests from the request queue logic.
- Returns lookup hit and slot results, and guarantees that free slots never match because it holds them ignored.
- The CAM itself is a separate instance with 1-cycle registered search latency.

Parameters:
CAM_WIDTH, 13, key width; must equal the CAM instance's CAM_WIDTH.
CAM_DEPTH, 16, number of slots; power of two, at least 2.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ins_valid  in  1  insert request
ins_ready  out  1  insert can be accepted
ins_key  in  CAM_WIDTH  key to store
ins_slot  out  log2(DEPTH)  slot being allocated; valid when ins_valid && ins_ready
lkp_valid  in  1  lookup request
lkp_ready  out  1  lookup can be accepted
lkp_key  in  CAM_WIDTH  key to search
rsp_valid  out  1  lookup result valid
rsp_hit  out  1  lookup matched
rsp_slot  out  log2(DEPTH)  matched slot (highest index on multiple matches)
rel_valid  in  1  release request
rel_slot  in  log2(DEPTH)  slot to free
rel_err  out  1  registered pulse: release of an already-free slot
flush_req  in  1  free all slots
flush_busy  out  1  flush in progress
occupancy  out  log2(DEPTH)+1  number of valid slots
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0
cam_we, cam_wr_addr, cam_din, cam_key, cam_se, cam_ignore  out  per CAM  connect to xvk_cam
cam_match, cam_match_addr  in  per CAM  from xvk_cam

Behaviour:
- Reset, when rst_n is low at a clk edge:
  - valid bitmap = 0, FSM = IDLE, occupancy = 0, rel_err = 0, in-flight flag = 0.
  - Resulting outputs: empty = 1, full = 0, flush_busy = 0, rsp_valid = 0.
  - Any in-flight lookup is discarded.
  - cam_ignore = all-ones from the first post-reset cycle, so the CAM scrubs every slot to all-ones.
- ins_ready = (FSM == IDLE) && !full.
  - On accept, in the same cycle: cam_we = 1, cam_wr_addr = ins_slot = lowest index with valid == 0 (from the registered bitmap), cam_din = ins_key.
  - valid[slot] is set at the next edge.
- lkp_ready = (FSM == IDLE).
  - On accept, in the same cycle: cam_se = 1, cam_key = lkp_key.
  - Set the in-flight flag.
  - Next cycle: rsp_valid = 1, rsp_hit = cam_match, rsp_slot = cam_match_addr.
  - Back-to-back lookups run every cycle; there is no response backpressure.
- When cam_se is 0, cam_key is driven with ins_key. It is don't-care.
- cam_ignore[k] = !valid[k] | (rel_valid && rel_slot == k) | (FSM == CLEAR). Exception: bit k is forced to 0 when cam_we writes slot k.
- Release:
  - Takes effect combinationally: a lookup in the same cycle misses the released slot.
  - valid[rel_slot] clears at the next edge.
  - Releasing a free slot: no state change, rel_err = 1 for one cycle after.
  - rel_valid is ignored outside IDLE.
- Simultaneous insert + release: independent. The insert never picks the slot being released, because that slot is still valid in the registered bitmap.
- occupancy next = occupancy + accepted insert − effective release; a simultaneous insert and release leaves it unchanged.
- Simultaneous insert + lookup of the same key: the CAM matches the write data, so the response is a hit on the new slot.
- Duplicate keys are allowed. The lookup returns the highest matching slot.
- The all-ones key is reserved. An insert with key all-ones is accepted but can never hit; a lookup with key all-ones always misses.
- FSM:
  - IDLE: flush_req goes to DRAIN if the in-flight flag is set, else to CLEAR. An insert, lookup or release presented in the same cycle as flush_req is not accepted.
  - DRAIN: exactly one cycle; the pending response is delivered; then CLEAR.
  - CLEAR: one cycle. cam_ignore = all-ones; valid cleared at the edge; occupancy reset to 0; then IDLE.
  - flush_busy = (FSM != IDLE).
- A reset mid-flush returns the FSM to IDLE with all slots free.

Test Plan:
- Reset, then 16 inserts of keys 0x001..0x010 → ins_slot 0..15 in order; full = 1 and ins_ready = 0 after the 16th; occupancy = 16.
- Lookup 0x005 → rsp_valid exactly 1 cycle later, rsp_hit = 1, rsp_slot = 4. Lookup 0x0FF → rsp_hit = 0.
- Release slot 4 and look up 0x005 in the same cycle → miss. The next insert (key 0x0AA) gets slot 4, and a lookup of 0x0AA then hits slot 4.
- Insert 0x123 and look up 0x123 in the same cycle, with slot 2 the lowest free → hit, rsp_slot = 2. Insert 0x123 again into slot 3, look up → rsp_slot = 3.
- Release of a free slot 7 → rel_err pulses 1 cycle; occupancy unchanged. Simultaneous insert + release of a different slot → occupancy unchanged.
- Lookup followed immediately by flush_req → response delivered, FSM goes DRAIN then CLEAR (flush_busy high 2 cycles). Afterwards empty = 1, and every prior key misses.
- Assert rst_n low mid-CLEAR → FSM returns to IDLE with empty = 1 and flush_busy = 0.

Source files
------------

// File: rtl/xvk_cam_alloc.sv
// ---------------------------------------------------------------------------
// xvk_cam_alloc
//
// Slot allocator and access sequencer for one xvk_cam instance. It keeps the
// valid bitmap of CAM slots and serialises insert, lookup, release and flush
// requests onto the CAM write/search/ignore ports. Free slots are always
// held ignored, so stale CAM contents never match.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   ins_valid/ins_ready    insert handshake; ins_key stored at ins_slot
//   lkp_valid/lkp_ready    lookup handshake; lkp_key searched
//   rsp_valid/hit/slot     lookup result, one cycle after lookup accept
//   rel_valid/rel_slot     release a slot; rel_err pulses on a free slot
//   flush_req/flush_busy   free every slot (drains an in-flight lookup first)
//   occupancy/full/empty   slot usage
//   cam_*                  connection to xvk_cam (1-cycle search latency)
// ---------------------------------------------------------------------------
module xvk_cam_alloc #(
  parameter int CAM_WIDTH = 13,
  parameter int CAM_DEPTH = 16,
  localparam int AW       = $clog2(CAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 ins_valid,
  output logic                 ins_ready,
  input  logic [CAM_WIDTH-1:0] ins_key,
  output logic [AW-1:0]        ins_slot,

  input  logic                 lkp_valid,
  output logic                 lkp_ready,
  input  logic [CAM_WIDTH-1:0] lkp_key,

  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [AW-1:0]        rsp_slot,

  input  logic                 rel_valid,
  input  logic [AW-1:0]        rel_slot,
  output logic                 rel_err,

  input  logic                 flush_req,
  output logic                 flush_busy,

  output logic [AW:0]          occupancy,
  output logic                 full,
  output logic                 empty,

  output logic                 cam_we,
  output logic [AW-1:0]        cam_wr_addr,
  output logic [CAM_WIDTH-1:0] cam_din,
  output logic [CAM_WIDTH-1:0] cam_key,
  output logic                 cam_se,
  output logic [CAM_DEPTH-1:0] cam_ignore,
  input  logic                 cam_match,
  input  logic [AW-1:0]        cam_match_addr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CAM_DEPTH-1:0] valid_q, valid_d;
  logic [AW:0]          occ_q, occ_d;
  logic                 inflight_q;
  logic                 rel_err_q;

  logic                 idle;
  logic                 clearing;
  logic                 ins_acc;
  logic                 lkp_acc;
  logic                 rel_acc;
  logic                 rel_eff;
  logic [AW-1:0]        free_slot;

  // ---------------------------------------------------------------------
  // Status and handshakes. A flush request blocks every other request in
  // the same cycle, so it is folded into the ready signals to keep the
  // handshake honest.
  // ---------------------------------------------------------------------
  assign idle       = (state_q == ST_IDLE);
  assign clearing   = (state_q == ST_CLEAR);
  assign full       = (occ_q == (AW+1)'(CAM_DEPTH));
  assign empty      = (occ_q == '0);
  assign occupancy  = occ_q;
  assign flush_busy = !idle;

  assign ins_ready  = idle && !full && !flush_req;
  assign lkp_ready  = idle && !flush_req;
  assign ins_acc    = ins_valid && ins_ready;
  assign lkp_acc    = lkp_valid && lkp_ready;
  assign rel_acc    = rel_valid && idle && !flush_req;
  // A release only counts when the slot is actually in use.
  assign rel_eff    = rel_acc && valid_q[rel_slot];

  // Lowest free slot from the registered bitmap. A slot being released this
  // cycle is still marked valid, so insert and release never collide.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    free_slot = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_slot = AW'(i);
    end
  end

  assign ins_slot = free_slot;

  // ---------------------------------------------------------------------
  // CAM port drive
  // ---------------------------------------------------------------------
  assign cam_we      = ins_acc;
  assign cam_wr_addr = free_slot;
  assign cam_din     = ins_key;
  assign cam_se      = lkp_acc;
  // Search key is don't-care when not searching; reuse ins_key to avoid an
  // extra mux input.
  assign cam_key     = lkp_acc ? lkp_key : ins_key;

  // Free slots, a slot being released and every slot during CLEAR are
  // ignored, which also makes the CAM scrub them to all-ones. The slot being
  // written is never ignored so a same-cycle search can see the new key.
  always_comb begin
    cam_ignore = '0;
    for (int k = 0; k < CAM_DEPTH; k++) begin
      cam_ignore[k] = !valid_q[k] || (rel_acc && rel_slot == AW'(k)) || clearing;
      if (ins_acc && free_slot == AW'(k)) cam_ignore[k] = 1'b0;
    end
  end

  // Response is the CAM's registered result for the lookup of last cycle.
  assign rsp_valid = inflight_q;
  assign rsp_hit   = inflight_q && cam_match;
  assign rsp_slot  = cam_match_addr;
  assign rel_err   = rel_err_q;

  // ---------------------------------------------------------------------
  // Next-state: bitmap, occupancy, FSM
  // ---------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    if (rel_eff) valid_d[rel_slot]  = 1'b0;
    if (ins_acc) valid_d[free_slot] = 1'b1;
  end

  assign occ_d = occ_q + (AW+1)'(ins_acc) - (AW+1)'(rel_eff);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (flush_req) state_d = inflight_q ? ST_DRAIN : ST_CLEAR;
      ST_DRAIN: state_d = ST_CLEAR;   // pending response goes out this cycle
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: only the slot bitmap is reset here; stale key storage in the CAM
  // is harmless because every free slot is held ignored and scrubbed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      rel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= lkp_acc;
      rel_err_q  <= rel_acc && !valid_q[rel_slot];
      if (clearing) begin
        valid_q <= '0;
        occ_q   <= '0;
      end else begin
        valid_q <= valid_d;
        occ_q   <= occ_d;
      end
    end
  end

endmodule

// File: tb/tb_xvk_cam_alloc.sv
// ---------------------------------------------------------------------------
// tb_xvk_cam_alloc
//
// Directed bench for xvk_cam_alloc. A small behavioural CAM stands in for
// xvk_cam. A slot-level model (key per slot, valid flags, busy countdown)
// predicts every DUT output each cycle; directed steps add literal
// expectations taken from the intended behaviour.
// ---------------------------------------------------------------------------
module tb_xvk_cam_alloc;

  localparam int W  = 13;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ins_valid, ins_ready;
  logic [W-1:0]  ins_key;
  logic [AW-1:0] ins_slot;
  logic          lkp_valid, lkp_ready;
  logic [W-1:0]  lkp_key;
  logic          rsp_valid, rsp_hit;
  logic [AW-1:0] rsp_slot;
  logic          rel_valid;
  logic [AW-1:0] rel_slot;
  logic          rel_err;
  logic          flush_req, flush_busy;
  logic [AW:0]   occupancy;
  logic          full, empty;
  logic          cam_we;
  logic [AW-1:0] cam_wr_addr;
  logic [W-1:0]  cam_din, cam_key;
  logic          cam_se;
  logic [D-1:0]  cam_ignore;
  logic          cam_match = 1'b0;
  logic [AW-1:0] cam_match_addr = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xvk_cam_alloc #(.CAM_WIDTH(W), .CAM_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_key(ins_key), .ins_slot(ins_slot),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_key(lkp_key),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_slot(rsp_slot),
    .rel_valid(rel_valid), .rel_slot(rel_slot), .rel_err(rel_err),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .occupancy(occupancy), .full(full), .empty(empty),
    .cam_we(cam_we), .cam_wr_addr(cam_wr_addr), .cam_din(cam_din),
    .cam_key(cam_key), .cam_se(cam_se), .cam_ignore(cam_ignore),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural CAM stand-in ----------------
  logic [W-1:0] cam_mem [D];

  always @(posedge clk) begin
    logic          hit;
    logic [AW-1:0] addr;
    logic [W-1:0]  entry;
    hit  = 1'b0;
    addr = '0;
    for (int k = 0; k < D; k++) begin
      entry = (cam_we && cam_wr_addr == AW'(k)) ? cam_din : cam_mem[k];
      if (cam_se && !cam_ignore[k] && cam_key != '1 && entry == cam_key) begin
        hit  = 1'b1;
        addr = AW'(k);
      end
    end
    cam_match      <= hit;
    cam_match_addr <= addr;
    for (int k = 0; k < D; k++) begin
      if (cam_we && cam_wr_addr == AW'(k)) cam_mem[k] <= cam_din;
      else if (cam_ignore[k])              cam_mem[k] <= '1;
    end
  end

  // ---------------- slot-level model + per-cycle compare ----------------
  bit           m_known = 1'b0;
  bit           m_valid [D];
  logic [W-1:0] m_key   [D];
  int           m_occ;
  int           m_flush_left;   // busy cycles still to come; 1 = clearing cycle
  bit           m_pend, m_hit, m_rel_err;
  int           m_slot;

  always @(negedge clk) begin
    int           free;
    bit           idle_e, full_e, ins_acc, lkp_acc, rel_acc, ent_v, h;
    int           s;
    logic [W-1:0] ent_k;
    logic [D-1:0] ign;

    free = D;
    for (int k = D - 1; k >= 0; k--) if (!m_valid[k]) free = k;
    idle_e  = (m_flush_left == 0);
    full_e  = (m_occ == D);
    ins_acc = ins_valid && idle_e && !full_e && !flush_req;
    lkp_acc = lkp_valid && idle_e && !flush_req;
    rel_acc = rel_valid && idle_e && !flush_req;

    if (m_known) begin
      check("occupancy",  32'(occupancy),  32'(m_occ));
      check("full",       32'(full),       32'(full_e));
      check("empty",      32'(empty),      32'(m_occ == 0));
      check("flush_busy", 32'(flush_busy), 32'(!idle_e));
      check("rel_err",    32'(rel_err),    32'(m_rel_err));
      check("rsp_valid",  32'(rsp_valid),  32'(m_pend));
      check("rsp_hit",    32'(rsp_hit),    32'(m_pend && m_hit));
      if (m_pend && m_hit) check("rsp_slot", 32'(rsp_slot), 32'(m_slot));
      check("cam_we", 32'(cam_we), 32'(ins_acc));
      check("cam_se", 32'(cam_se), 32'(lkp_acc));
      if (ins_acc) begin
        check("ins_slot",    32'(ins_slot),    32'(free));
        check("cam_wr_addr", 32'(cam_wr_addr), 32'(free));
        check("cam_din",     32'(cam_din),     32'(ins_key));
      end
      if (lkp_acc) check("cam_key", 32'(cam_key), 32'(lkp_key));
      if (!flush_req) begin
        check("ins_ready", 32'(ins_ready), 32'(idle_e && !full_e));
        check("lkp_ready", 32'(lkp_ready), 32'(idle_e));
      end
      if (m_flush_left == 1) begin
        check("cam_ignore_clear", 32'(cam_ignore), 32'({D{1'b1}}));
      end else if (idle_e && !flush_req) begin
        for (int k = 0; k < D; k++)
          ign[k] = (!m_valid[k] || (rel_acc && int'(rel_slot) == k)) && !(ins_acc && free == k);
        check("cam_ignore", 32'(cam_ignore), 32'(ign));
      end
    end

    if (!rst_n) begin
      for (int k = 0; k < D; k++) m_valid[k] = 1'b0;
      m_occ = 0; m_flush_left = 0; m_pend = 1'b0; m_hit = 1'b0;
      m_slot = 0; m_rel_err = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      if (idle_e && flush_req) m_flush_left = m_pend ? 2 : 1;
      else if (m_flush_left > 0) begin
        if (m_flush_left == 1) begin
          for (int k = 0; k < D; k++) m_valid[k] = 1'b0;
          m_occ = 0;
        end
        m_flush_left--;
      end
      if (lkp_acc) begin
        h = 1'b0; s = 0;
        if (lkp_key != '1) begin
          for (int k = 0; k < D; k++) begin
            ent_v = (ins_acc && free == k) || (m_valid[k] && !(rel_acc && int'(rel_slot) == k));
            ent_k = (ins_acc && free == k) ? ins_key : m_key[k];
            if (ent_v && ent_k == lkp_key) begin h = 1'b1; s = k; end
          end
        end
        m_hit = h; m_slot = s;
      end
      m_pend    = lkp_acc;
      m_rel_err = rel_acc && !m_valid[rel_slot];
      if (rel_acc && m_valid[rel_slot]) begin
        m_valid[rel_slot] = 1'b0;
        m_occ--;
      end
      if (ins_acc) begin
        m_valid[free] = 1'b1;
        m_key[free]   = ins_key;
        m_occ++;
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_insert(input logic [W-1:0] key, input int exp_slot);
    ins_valid = 1'b1;
    ins_key   = key;
    @(negedge clk);
    check("lit_ins_ready", 32'(ins_ready), 32'd1);
    check("lit_ins_slot",  32'(ins_slot),  32'(exp_slot));
    tick();
    ins_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [W-1:0] key, input bit exp_hit, input int exp_slot);
    lkp_valid = 1'b1;
    lkp_key   = key;
    tick();
    lkp_valid = 1'b0;
    @(negedge clk);
    check("lit_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lit_rsp_hit",   32'(rsp_hit),   32'(exp_hit));
    if (exp_hit) check("lit_rsp_slot", 32'(rsp_slot), 32'(exp_slot));
    tick();
  endtask

  task automatic do_release(input int slot);
    rel_valid = 1'b1;
    rel_slot  = AW'(slot);
    tick();
    rel_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ins_valid = 1'b0; ins_key = '0;
    lkp_valid = 1'b0; lkp_key = '0;
    rel_valid = 1'b0; rel_slot = '0;
    flush_req = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("lit_rst_empty",      32'(empty),      32'd1);
    check("lit_rst_full",       32'(full),       32'd0);
    check("lit_rst_flush_busy", 32'(flush_busy), 32'd0);
    check("lit_rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("lit_rst_ignore",     32'(cam_ignore), 32'h0000_ffff);
    tick();
    rst_n = 1'b1;

    // Fill all 16 slots in order
    for (int i = 0; i < D; i++) do_insert(W'(i + 1), i);
    @(negedge clk);
    check("lit_full",      32'(full),      32'd1);
    check("lit_full_rdy",  32'(ins_ready), 32'd0);
    check("lit_occ16",     32'(occupancy), 32'd16);
    tick();

    // Lookup hit, response exactly one cycle wide; then a miss
    do_lookup(13'h005, 1'b1, 4);
    @(negedge clk);
    check("lit_rsp_one_cycle", 32'(rsp_valid), 32'd0);
    tick();
    do_lookup(13'h0FF, 1'b0, 0);

    // Release slot 4 while looking up its key -> miss; reuse slot 4
    rel_valid = 1'b1; rel_slot = 4'd4;
    lkp_valid = 1'b1; lkp_key = 13'h005;
    tick();
    rel_valid = 1'b0; lkp_valid = 1'b0;
    @(negedge clk);
    check("lit_rel_lkp_hit", 32'(rsp_hit),   32'd0);
    check("lit_rel_occ",     32'(occupancy), 32'd15);
    tick();
    do_insert(13'h0AA, 4);
    do_lookup(13'h0AA, 1'b1, 4);

    // Insert and lookup of the same key in one cycle, then a duplicate key
    do_release(2);
    do_release(3);
    ins_valid = 1'b1; ins_key = 13'h123;
    lkp_valid = 1'b1; lkp_key = 13'h123;
    @(negedge clk);
    check("lit_same_ins_slot", 32'(ins_slot), 32'd2);
    tick();
    ins_valid = 1'b0; lkp_valid = 1'b0;
    @(negedge clk);
    check("lit_same_hit",  32'(rsp_hit),  32'd1);
    check("lit_same_slot", 32'(rsp_slot), 32'd2);
    tick();
    do_insert(13'h123, 3);
    do_lookup(13'h123, 1'b1, 3);

    // Double release of slot 7 -> rel_err one-cycle pulse, occupancy unchanged
    do_release(7);
    do_release(7);
    @(negedge clk);
    check("lit_rel_err",     32'(rel_err),   32'd1);
    check("lit_rel_err_occ", 32'(occupancy), 32'd15);
    tick();
    @(negedge clk);
    check("lit_rel_err_gone", 32'(rel_err), 32'd0);
    tick();

    // Insert + release of a different slot -> occupancy unchanged
    ins_valid = 1'b1; ins_key = 13'h0BB;
    rel_valid = 1'b1; rel_slot = 4'd9;
    @(negedge clk);
    check("lit_insrel_slot", 32'(ins_slot), 32'd7);
    tick();
    ins_valid = 1'b0; rel_valid = 1'b0;
    @(negedge clk);
    check("lit_insrel_occ", 32'(occupancy), 32'd15);
    tick();
    do_lookup(13'h00A, 1'b0, 0);

    // Reserved all-ones key: accepted, never hits
    do_insert(13'h1FFF, 9);
    do_lookup(13'h1FFF, 1'b0, 0);

    // Lookup immediately followed by flush -> DRAIN, CLEAR
    lkp_valid = 1'b1; lkp_key = 13'h001;
    tick();
    lkp_valid = 1'b0; flush_req = 1'b1;
    @(negedge clk);
    check("lit_fl_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lit_fl_rsp_slot",  32'(rsp_slot),  32'd0);
    tick();
    flush_req = 1'b0;
    @(negedge clk);
    check("lit_drain_busy", 32'(flush_busy), 32'd1);
    check("lit_drain_rdy",  32'(lkp_ready),  32'd0);
    tick();
    @(negedge clk);
    check("lit_clear_busy",   32'(flush_busy), 32'd1);
    check("lit_clear_ignore", 32'(cam_ignore), 32'h0000_ffff);
    tick();
    @(negedge clk);
    check("lit_post_fl_busy",  32'(flush_busy), 32'd0);
    check("lit_post_fl_empty", 32'(empty),      32'd1);
    tick();
    do_lookup(13'h001, 1'b0, 0);
    do_lookup(13'h005, 1'b0, 0);
    do_lookup(13'h123, 1'b0, 0);
    do_lookup(13'h0AA, 1'b0, 0);

    // Flush without an in-flight lookup, reset asserted during CLEAR
    do_insert(13'h010, 0);
    do_insert(13'h011, 1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    check("lit_direct_clear", 32'(flush_busy), 32'd1);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("lit_rst_mid_busy",  32'(flush_busy), 32'd0);
    check("lit_rst_mid_empty", 32'(empty),      32'd1);
    tick();
    do_insert(13'h020, 0);
    do_lookup(13'h020, 1'b1, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
